// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with valid/ready on both the load and serial sides.
// Optional SER_PARITY_EN appends an even-parity beat after the data bits.
module piso_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_last,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam int unsigned SW = WIDTH + 1;
`else
  localparam int unsigned SW = WIDTH;
`endif
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(SW - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e          state_q;
  logic [SW-1:0]   shreg_q;
  logic [CntW-1:0] cnt_q;

  logic          cnt_zero;
  logic          load_xfer;
  logic [SW-1:0] load_word;
  logic [SW-1:0] shreg_shifted;

  assign cnt_zero   = (cnt_q == '0);
  assign load_ready = (state_q == StIdle) | ((state_q == StShift) & cnt_zero & ser_ready);
  assign load_xfer  = load_valid & load_ready;

  // Parity sits at the tail end of the word so it drains out after the data bits.
  always_comb begin
    load_word = '0;
`ifdef SER_PARITY_EN
    if (MSB_FIRST) load_word = {load_data, ^load_data};
    else           load_word = {^load_data, load_data};
`else
    load_word = load_data;
`endif
  end

  always_comb begin
    shreg_shifted = '0;
    if (MSB_FIRST) shreg_shifted = {shreg_q[SW-2:0], 1'b0};
    else           shreg_shifted = {1'b0, shreg_q[SW-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_xfer) begin
            shreg_q <= load_word;
            cnt_q   <= CntLoad;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (ser_ready) begin
            if (!cnt_zero) begin
              shreg_q <= shreg_shifted;
              cnt_q   <= cnt_q - CntW'(1);
            end else if (load_valid) begin
              shreg_q <= load_word;
              cnt_q   <= CntLoad;
            end else begin
              // Final shift zero-fills, so ser_out rests at 0 in idle.
              shreg_q <= shreg_shifted;
              state_q <= StIdle;
            end
          end
        end
      endcase
    end
  end

  assign busy      = (state_q == StShift);
  assign ser_valid = (state_q == StShift);
  assign ser_last  = (state_q == StShift) & cnt_zero;
  assign ser_out   = MSB_FIRST ? shreg_q[SW-1] : shreg_q[0];

endmodule
